// File: rtl/ova_sequencer_if.sv
// ova_sequencer_if: tile handshake, OVA control and row-stream signals of the OVA frame sequencer.
// The master modport is the sequencer; the slave modport is its surroundings.
interface ova_sequencer_if #(
    parameter int NUM_BLOCK_ROOT = 4,
    parameter int SIZE = 4,
    parameter int OVERLAP = 1
);
    localparam int NB = NUM_BLOCK_ROOT * NUM_BLOCK_ROOT;
    localparam int OUTSIZE = NUM_BLOCK_ROOT * SIZE - (NUM_BLOCK_ROOT - 1) * OVERLAP;
    localparam int IW = $clog2(NB);
    localparam int OW = $clog2(OUTSIZE);
    logic start;
    logic busy;
    logic done;
    logic blk_valid;
    logic blk_ready;
    logic [IW-1:0] blk_index;
    logic [OW-1:0] tile_row_base;
    logic [OW-1:0] tile_col_base;
    logic ova_reset;
    logic ova_control;
    logic out_row_valid;
    logic out_row_ready;
    logic [OW-1:0] out_row_idx;
    modport master (
        input start, blk_valid, out_row_ready,
        output busy, done, blk_ready, blk_index, tile_row_base, tile_col_base,
        output ova_reset, ova_control, out_row_valid, out_row_idx
    );
    modport slave (
        output start, blk_valid, out_row_ready,
        input busy, done, blk_ready, blk_index, tile_row_base, tile_col_base,
        input ova_reset, ova_control, out_row_valid, out_row_idx
    );
endinterface

// File: rtl/ova_sequencer.sv
// ova_sequencer: clears the OVA accumulator, feeds it one frame of tiles, then streams output rows.
module ova_sequencer #(
    parameter int NUM_BLOCK_ROOT = 4,
    parameter int SIZE = 4,
    parameter int OVERLAP = 1
) (
    input logic clk,
    input logic reset,
    ova_sequencer_if.master bus
);
    localparam int NB = NUM_BLOCK_ROOT * NUM_BLOCK_ROOT;
    localparam int OUTSIZE = NUM_BLOCK_ROOT * SIZE - (NUM_BLOCK_ROOT - 1) * OVERLAP;
    localparam int IW = $clog2(NB);
    localparam int OW = $clog2(OUTSIZE);
    localparam int STEP = SIZE - OVERLAP;
    typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, SETTLE, READOUT, DONE} state_t;
    state_t state_q, state_d;
    logic [IW-1:0] cnt_q, cnt_d;
    logic [OW-1:0] row_q, row_d;
    logic accum, readout, blk_hs, row_hs, last_blk, last_row;
    assign accum = state_q == ACCUM;
    assign readout = state_q == READOUT;
    assign blk_hs = accum && bus.blk_valid;
    assign row_hs = readout && bus.out_row_ready;
    assign last_blk = cnt_q == IW'(NB - 1);
    assign last_row = row_q == OW'(OUTSIZE - 1);
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q <= '0;
            row_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            row_q <= row_d;
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        row_d = row_q;
        case (state_q)
            IDLE: state_d = bus.start ? CLEAR : IDLE;
            CLEAR: begin
                state_d = ACCUM;
                cnt_d = '0;
                row_d = '0;
            end
            ACCUM: if (blk_hs) begin
                state_d = last_blk ? SETTLE : ACCUM;
                cnt_d = last_blk ? '0 : cnt_q + IW'(1);
            end
            SETTLE: state_d = READOUT;
            READOUT: if (row_hs) begin
                state_d = last_row ? DONE : READOUT;
                row_d = last_row ? '0 : row_q + OW'(1);
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        bus.busy = state_q != IDLE;
        bus.done = state_q == DONE;
        bus.ova_reset = state_q == CLEAR;
        bus.blk_ready = accum;
        bus.ova_control = blk_hs;
        bus.blk_index = accum ? cnt_q : '0;
        // Tile origin in the output grid: row/column of the tile times the non-overlapping stride.
        bus.tile_row_base = accum ? OW'((int'(cnt_q) / NUM_BLOCK_ROOT) * STEP) : '0;
        bus.tile_col_base = accum ? OW'((int'(cnt_q) % NUM_BLOCK_ROOT) * STEP) : '0;
        bus.out_row_valid = readout;
        bus.out_row_idx = readout ? row_q : '0;
    end
    ova_excl: assert property (@(posedge clk) disable iff (reset) !(bus.ova_reset && bus.ova_control));
    rdy_in_accum: assert property (@(posedge clk) disable iff (reset) bus.blk_ready |-> state_q == ACCUM);
    row_hold: assert property (@(posedge clk) disable iff (reset)
        bus.out_row_valid && !bus.out_row_ready |=> bus.out_row_valid && $stable(bus.out_row_idx));
endmodule

// File: tb/tb_ova_sequencer.sv
// tb_ova_sequencer: scoreboard bench; stimulus queues the expected frame events, a monitor pops and compares.
module tb_ova_sequencer;
    localparam int NBR = 4;
    localparam int SIZE = 4;
    localparam int OVERLAP = 1;
    localparam int NB = NBR * NBR;
    localparam int OUTSIZE = NBR * SIZE - (NBR - 1) * OVERLAP;
    localparam int STEP = SIZE - OVERLAP;
    localparam int EV_CLR = 0, EV_TILE = 1, EV_ROW = 2, EV_DONE = 3;
    typedef struct {int kind; int a; int b; int c;} ev_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int cyc = 0, checks = 0, failures = 0, t0 = 0;
    int clr_cyc = -1, done_cyc = -1, first_rdy = -1, pulses = 0;
    int tile_cyc[NB];
    int row_cyc[OUTSIZE];
    bit prev_hold = 0;
    int prev_idx = 0;
    ev_t exp_q[$];
    ova_sequencer_if #(.NUM_BLOCK_ROOT(NBR), .SIZE(SIZE), .OVERLAP(OVERLAP)) bus();
    ova_sequencer #(.NUM_BLOCK_ROOT(NBR), .SIZE(SIZE), .OVERLAP(OVERLAP)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic see(input int k, input int a, input int b, input int c);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event kind=%0d a=%0d at frame cycle %0d, required none", k, a, cyc - t0);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.a != a || e.b != b || e.c != c) begin
                failures++;
                $display("FAIL event actual kind=%0d a=%0d b=%0d c=%0d required kind=%0d a=%0d b=%0d c=%0d",
                         k, a, b, c, e.kind, e.a, e.b, e.c);
            end
        end
    endtask

    task automatic idle_zero(input string name);
        chk(name, int'({bus.busy, bus.done, bus.blk_ready, bus.blk_index, bus.tile_row_base, bus.tile_col_base,
                        bus.ova_reset, bus.ova_control, bus.out_row_valid, bus.out_row_idx}), 0);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            chk("ova_exclusive", int'(bus.ova_reset && bus.ova_control), 0);
            chk("ova_control_hs", int'(bus.ova_control), int'(bus.blk_valid && bus.blk_ready));
            chk("ready_valid_exclusive", int'(bus.blk_ready && bus.out_row_valid), 0);
            if (prev_hold) begin
                chk("row_valid_hold", int'(bus.out_row_valid), 1);
                chk("row_idx_hold", int'(bus.out_row_idx), prev_idx);
            end
            prev_hold = bus.out_row_valid && !bus.out_row_ready;
            prev_idx = int'(bus.out_row_idx);
            if (bus.blk_ready && first_rdy < 0) first_rdy = cyc - t0;
            if (bus.ova_reset) begin
                clr_cyc = cyc - t0;
                see(EV_CLR, 0, 0, 0);
            end
            if (bus.ova_control) begin
                pulses++;
                tile_cyc[bus.blk_index] = cyc - t0;
                see(EV_TILE, int'(bus.blk_index), int'(bus.tile_row_base), int'(bus.tile_col_base));
            end
            if (bus.out_row_valid && bus.out_row_ready) begin
                if (int'(bus.out_row_idx) < OUTSIZE) row_cyc[bus.out_row_idx] = cyc - t0;
                see(EV_ROW, int'(bus.out_row_idx), 0, 0);
            end
            if (bus.done) begin
                done_cyc = cyc - t0;
                see(EV_DONE, 0, 0, 0);
            end
        end else prev_hold = 0;
    end

    task automatic run_frame(input bit rnd, input int stall_tile, input int stall_len,
                             input int bp_row, input int bp_len, input int abort_tile);
        int nt, st, bp, extra;
        bit fin, stalled, held;
        nt = abort_tile >= 0 ? abort_tile : NB;
        exp_q.push_back('{EV_CLR, 0, 0, 0});
        for (int i = 0; i < nt; i++) exp_q.push_back('{EV_TILE, i, (i / NBR) * STEP, (i % NBR) * STEP});
        if (abort_tile < 0) begin
            for (int r = 0; r < OUTSIZE; r++) exp_q.push_back('{EV_ROW, r, 0, 0});
            exp_q.push_back('{EV_DONE, 0, 0, 0});
        end
        pulses = 0; first_rdy = -1; done_cyc = -1; clr_cyc = -1;
        st = 0; bp = 0; extra = 0; fin = 0;
        @(posedge clk); #1;
        bus.start = 1'b1;
        t0 = cyc;
        for (int k = 0; k < 400 && !fin; k++) begin
            @(posedge clk); #1;
            if (!bus.busy) begin
                bus.start = 1'b0;
                fin = 1;
            end else if (abort_tile >= 0 && bus.blk_ready && int'(bus.blk_index) == abort_tile) begin
                bus.blk_valid = 1'b0;
                bus.start = 1'b0;
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                idle_zero("abort_outputs_zero");
                fin = 1;
            end else begin
                // start while busy (random, mid-ACCUM and in DONE) must be ignored
                bus.start = (rnd && $urandom_range(0, 5) == 0) || bus.done || (bus.blk_ready && int'(bus.blk_index) == 3);
                bus.blk_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                bus.out_row_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                stalled = bus.blk_ready && int'(bus.blk_index) == stall_tile + 1 && st < stall_len;
                held = bus.out_row_valid && int'(bus.out_row_idx) == bp_row && bp < bp_len;
                if (stalled) begin bus.blk_valid = 1'b0; st++; end
                if (held) begin bus.out_row_ready = 1'b0; bp++; end
                if (bus.blk_ready && !bus.blk_valid) extra++;
                if (bus.out_row_valid && !bus.out_row_ready) extra++;
                #1;
                if (stalled) begin
                    chk("stall_no_ova", int'(bus.ova_control), 0);
                    chk("stall_idx", int'(bus.blk_index), stall_tile + 1);
                end
                if (held) begin
                    chk("bp_idx", int'(bus.out_row_idx), bp_row);
                    chk("bp_valid", int'(bus.out_row_valid), 1);
                end
            end
        end
        chk("frame_terminated", int'(fin), 1);
        chk("clear_cycle", clr_cyc, 1);
        chk("pulse_count", pulses, nt);
        if (abort_tile >= 0) begin
            repeat (5) @(posedge clk);
            #1;
            idle_zero("after_abort_idle");
        end else begin
            chk("first_ready_latency", first_rdy, 2);
            chk("done_cycle", done_cyc, 3 + NB + OUTSIZE + extra);
        end
        chk("queue_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        bus.start = 1'b0;
        bus.blk_valid = 1'b0;
        bus.out_row_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        idle_zero("reset_state");
        run_frame(0, -1, 0, -1, 0, -1);
        for (int i = 0; i < NB; i++) chk("tile_cycle", tile_cyc[i], 2 + i);
        for (int r = 0; r < OUTSIZE; r++) chk("row_cycle", row_cyc[r], 19 + r);
        chk("done_cycle_nostall", done_cyc, 32);
        run_frame(0, 7, 4, 6, 3, -1);
        chk("done_cycle_stall_bp", done_cyc, 39);
        run_frame(0, -1, 0, -1, 0, 10);
        run_frame(0, -1, 0, -1, 0, -1);
        for (int f = 0; f < 6; f++) run_frame(1, -1, 0, -1, 0, -1);
        repeat (20) @(posedge clk);
        #1;
        idle_zero("final_idle");
        chk("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ova_sequencer.md
# ova_sequencer

Sequencer for the overlap-add (OVA) accumulation unit. It runs one full frame: it clears the accumulator, accepts `NUM_BLOCK_ROOT*NUM_BLOCK_ROOT` tiles from the upstream tile producer through a valid/ready handshake, and drives the OVA enable exactly once per accepted tile. It then streams the assembled output rows to the downstream consumer. It sits between the tile producer, the OVA datapath and the row consumer, and owns all frame-level counting.

## Interface
- `NUM_BLOCK_ROOT`, 4, tiles per output edge; frame holds `NB = NUM_BLOCK_ROOT**2` tiles.
- `SIZE`, 4, tile edge length in elements.
- `OVERLAP`, 1, overlap between adjacent tiles in elements.
- `OUTSIZE` (derived), `NUM_BLOCK_ROOT*SIZE-(NUM_BLOCK_ROOT-1)*OVERLAP`, output edge length (13 at defaults).
- `clk` in 1: clock, all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: frame request; sampled only in IDLE.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at frame end.
- `blk_valid` in 1: upstream tile present.
- `blk_ready` out 1: sequencer accepts a tile this cycle.
- `blk_index` out `$clog2(NB)`: index of the tile being accepted; drives the OVA tile select.
- `tile_row_base` out `$clog2(OUTSIZE)`: `(blk_index/NUM_BLOCK_ROOT)*(SIZE-OVERLAP)`.
- `tile_col_base` out `$clog2(OUTSIZE)`: `(blk_index%NUM_BLOCK_ROOT)*(SIZE-OVERLAP)`.
- `ova_reset` out 1: clears OVA accumulator and its tile counter.
- `ova_control` out 1: OVA accumulate enable.
- `out_row_valid` out 1: output row `out_row_idx` is presented.
- `out_row_ready` in 1: consumer takes the row.
- `out_row_idx` out `$clog2(OUTSIZE)`: output row select, 0..OUTSIZE-1.

## Operation
- FSM states: IDLE, CLEAR, ACCUM, SETTLE, READOUT, DONE.
- IDLE: all outputs 0. `start=1` moves to CLEAR; `start=0` stays.
- CLEAR: exactly 1 cycle. `ova_reset=1`, `ova_control=0`. Tile counter is cleared. Next state is ACCUM.
- ACCUM:
  - `blk_ready=1`.
  - `ova_control = blk_valid & blk_ready` (combinational). The OVA adds the tile on that edge.
  - On each handshake the tile counter increments.
  - The handshake with counter `NB-1` moves to SETTLE.
  - `blk_valid=0` stalls indefinitely with no OVA activity.
- SETTLE: 1 cycle, all handshakes low, so the last accumulation is registered in the OVA before readout.
- READOUT:
  - `out_row_valid=1`; `out_row_idx` starts at 0.
  - A cycle with `out_row_valid & out_row_ready` advances `out_row_idx`.
  - The handshake at `OUTSIZE-1` moves to DONE.
  - `out_row_idx` holds while `out_row_ready=0`.
- DONE: `done=1` for 1 cycle, then IDLE.
- Invariants:
  - `ova_reset` and `ova_control` are never high in the same cycle.
  - `ova_control` pulses exactly NB times per frame.
  - `blk_ready` is 0 outside ACCUM.
  - `out_row_valid` is 0 outside READOUT.
- `blk_index`, `tile_row_base` and `tile_col_base` reflect the current counter in ACCUM and are 0 elsewhere.
- Arithmetic: unsigned. Base offsets never exceed `OUTSIZE-SIZE` (9 at defaults); no wrap-around.
- `start` while busy is ignored; the frame in progress is unaffected.

## Timing
- Reset: every state register and output is 0 and the FSM is in IDLE on the cycle after reset is sampled high.
- Reset mid-frame aborts immediately with no `done`. The next frame always starts with CLEAR, so stale OVA contents are never read.
- `reset` has priority over every other input.
- Latency, `start` to first `blk_ready`: 2 cycles (IDLE→CLEAR→ACCUM).
- Minimum frame length with no stalls: 1 (CLEAR) + NB + 1 (SETTLE) + OUTSIZE + 1 (DONE) = 32 cycles at defaults, plus 1 for the IDLE sampling of `start`.
- Handshakes are standard valid/ready. The sequencer never drops `blk_ready` mid-ACCUM and never deasserts `out_row_valid` before the handshake.
- Simultaneous DONE and `start`: `start` is ignored in DONE; it must be held or reissued in IDLE.

## Test plan
- Reset, then `start` pulse with `blk_valid` held high and `out_row_ready` held high:
  - `ova_reset` is high on cycle 1.
  - `ova_control` is high on cycles 2..17, with `blk_index` 0..15.
  - `out_row_idx` runs 0..12 on cycles 19..31.
  - `done` is high on cycle 32.
- Tile bases at defaults:
  - `blk_index=5` gives row base 3, col base 3.
  - `blk_index=15` gives 9, 9.
  - `blk_index=3` gives 0, 9.
- Stall on `blk_valid`: deassert it for 4 cycles after tile 7.
  - No `ova_control` during the stall; `blk_index` holds at 8.
  - Frame completes 4 cycles later, with exactly 16 `ova_control` pulses in total.
- Backpressure on readout: `out_row_ready` low for 3 cycles at row 6.
  - `out_row_idx` holds at 6 with `out_row_valid=1`.
  - No row is skipped or duplicated.
- Reset asserted during ACCUM at tile 10:
  - Next cycle is IDLE with all outputs 0 and no `done`.
  - A new `start` produces the CLEAR pulse and `blk_index` restarts at 0.
- `start` pulsed during ACCUM and during DONE: no effect on the counters. A second frame begins only on a `start` sampled in IDLE.
